// File: rtl/dccm_store_buffer_pkg.sv
// dccm_store_buffer_pkg: shared sizes, entry type and address helper
// for the DCCM store buffer and its match CAM.
package dccm_store_buffer_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW = 14;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_AW-1:0] waddr;
    logic [31:0]      data;
  } sb_entry_t;

  function automatic logic [SB_AW-1:0] waddr_of(
    input logic [31:0] a
  );
    return a[SB_AW+1:2];
  endfunction
endpackage

// File: rtl/dccm_sb_match.sv
// dccm_sb_match: combinational CAM over the valid store-buffer
// entries; reports the youngest entry whose word address matches.
module dccm_sb_match
  import dccm_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  sb_entry_t        i_mem [DEPTH],
  input  logic [PW-1:0]    i_head,
  input  logic [PW:0]      i_count,
  input  logic [SB_AW-1:0] i_waddr,
  output logic             o_hit,
  output logic [PW-1:0]    o_idx,
  output logic [31:0]      o_data
);
  always_comb begin : scan
    logic [PW-1:0] slot;
    o_hit  = 1'b0;
    o_idx  = '0;
    o_data = '0;
    slot   = '0;
    // oldest to youngest, so the last match wins
    for (int k = 0; k < DEPTH; k++) begin
      slot = i_head + PW'(k);
      if (((PW+1)'(k) < i_count) &&
          (i_mem[slot].waddr == i_waddr)) begin
        o_hit  = 1'b1;
        o_idx  = slot;
        o_data = i_mem[slot].data;
      end
    end
  end
endmodule

// File: rtl/dccm_store_buffer.sv
// dccm_store_buffer: FIFO store buffer in front of a 1-port SRAM.
// Define DCCM_STORE_COALESCE_EN to merge stores to buffered words.
module dccm_store_buffer
  import dccm_store_buffer_pkg::*;
#(
  parameter int DEPTH   = SB_DEPTH,
  parameter int SRAM_AW = SB_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               core_wr_en,
  input  logic [31:0]        core_wr_addr,
  input  logic [31:0]        core_wr_data,
  input  logic               core_rd_en,
  input  logic [31:0]        core_rd_addr,
  output logic [31:0]        core_rd_data,
  output logic               stall_o,
  input  logic               drain_req,
  output logic               idle_o,
  output logic               sram_cs,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  sb_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic          r_rd_valid;
  logic          r_hit;
  logic [31:0]   r_fwd;

  logic [SB_AW-1:0] w_wr_waddr;
  logic [SB_AW-1:0] w_rd_waddr;
  logic             w_buf_hit;
  logic [PW-1:0]    w_rd_idx_unused;
  logic [31:0]      w_buf_data;
  sb_entry_t        w_head_e;
  logic             w_empty;
  logic             w_blk;
  logic             w_wr_fwd;
  logic             w_rd_hit;
  logic             w_rd_miss;
  logic             w_pop;
  logic             w_co;
  logic             w_acc;
  logic             w_push;

  assign w_wr_waddr = waddr_of(core_wr_addr);
  assign w_rd_waddr = waddr_of(core_rd_addr);
  assign w_head_e   = r_mem[r_head];
  assign w_empty    = (r_count == '0);

  dccm_sb_match #(.DEPTH(DEPTH)) u_rd_match (
    .i_mem   (r_mem),
    .i_head  (r_head),
    .i_count (r_count),
    .i_waddr (w_rd_waddr),
    .o_hit   (w_buf_hit),
    .o_idx   (w_rd_idx_unused),
    .o_data  (w_buf_data)
  );

  assign w_blk    = drain_req && !w_empty;
  // a full buffer still takes a forwarded store: the hit frees a drain
  assign w_wr_fwd = core_wr_en && !w_blk &&
                    (w_wr_waddr == w_rd_waddr);
  assign w_rd_hit  = w_wr_fwd || w_buf_hit;
  assign w_rd_miss = rst_n && core_rd_en && !w_rd_hit;
  assign w_pop     = rst_n && !w_rd_miss && !w_empty;

`ifdef DCCM_STORE_COALESCE_EN
  logic          w_wr_hit;
  logic [PW-1:0] w_wr_idx;
  logic [31:0]   w_wr_data_unused;

  dccm_sb_match #(.DEPTH(DEPTH)) u_wr_match (
    .i_mem   (r_mem),
    .i_head  (r_head),
    .i_count (r_count),
    .i_waddr (w_wr_waddr),
    .o_hit   (w_wr_hit),
    .o_idx   (w_wr_idx),
    .o_data  (w_wr_data_unused)
  );

  assign w_co = rst_n && core_wr_en && !w_blk && w_wr_hit &&
                !(w_pop && (w_wr_idx == r_head));
`else
  assign w_co = 1'b0;
`endif

  assign w_acc  = rst_n && core_wr_en && !w_blk &&
                  (w_co || w_pop || (r_count != FULL));
  assign w_push = w_acc && !w_co;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_hit      <= 1'b0;
      r_fwd      <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + PW'(1);
      if (w_pop)
        r_head <= r_head + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + (PW+1)'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - (PW+1)'(1);
      r_rd_valid <= core_rd_en;
      r_hit      <= w_rd_hit;
      r_fwd      <= w_wr_fwd ? core_wr_data : w_buf_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_tail] <= '{waddr: w_wr_waddr, data: core_wr_data};
`ifdef DCCM_STORE_COALESCE_EN
    if (w_co)
      r_mem[w_wr_idx].data <= core_wr_data;
`endif
  end

  assign core_rd_data = !r_rd_valid ? '0 :
                        r_hit ? r_fwd : sram_rdata;
  assign stall_o    = rst_n && core_wr_en && !w_acc;
  assign idle_o     = w_empty;
  assign sram_cs    = w_rd_miss || w_pop;
  assign sram_we    = w_pop;
  assign sram_addr  = w_rd_miss ? w_rd_waddr :
                      w_pop ? w_head_e.waddr : '0;
  assign sram_wdata = w_pop ? w_head_e.data : '0;
endmodule

// File: doc/dccm_store_buffer.md
Name: dccm_store_buffer

Overview:
- Sits directly downstream of the core's DCCM ports, between the core and a single-port synchronous data SRAM.
- Absorbs stores into a small FIFO write buffer and drains them when the SRAM is free.
- Reads are served with 1-cycle latency, and data is forwarded from buffered or same-cycle stores.
- Applies back-pressure (stall_o) only when a store cannot be buffered.

Parameters:
- DEPTH, 4, number of store-buffer entries (power of 2, at least 2).
- SRAM_AW, 14, SRAM word-address width (64 KiB).

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset
- core_wr_en  input  1  store request
- core_wr_addr  input  32  store byte address
- core_wr_data  input  32  store word
- core_rd_en  input  1  load request
- core_rd_addr  input  32  load byte address
- core_rd_data  output  32  load data, valid the cycle after core_rd_en
- stall_o  output  1  combinational; this cycle's store is not accepted, so the core holds the request
- drain_req  input  1  force drain; blocks new store acceptance until empty
- idle_o  output  1  buffer empty
- sram_cs  output  1  SRAM access this cycle
- sram_we  output  1  SRAM write (valid when sram_cs=1)
- sram_addr  output  SRAM_AW  SRAM word address
- sram_wdata  output  32  SRAM write data
- sram_rdata  input  32  SRAM read data, one cycle after a read

Behaviour:
- Single clock clk; reset is synchronous and active-low on rst_n.
- Word addressing: waddr = addr[SRAM_AW+1:2]. Low 2 bits and bits above SRAM_AW+1 are ignored, so addresses alias. Word granularity only.
- Buffer is a circular FIFO: head/tail pointers wrap at DEPTH; count ranges 0..DEPTH. Each entry holds {waddr, data}.
- Read hit is evaluated in priority order:
  - incoming store with matching waddr (when core_wr_en=1 and the store is not stalled);
  - otherwise the youngest matching buffer entry;
  - otherwise miss.
- Per-cycle SRAM arbitration:
  - Read miss: SRAM read (cs=1, we=0); no drain this cycle.
  - Otherwise, if count>0: drain the head (cs=1, we=1, head entry), then pop.
  - Otherwise: cs=0.
- Store acceptance:
  - Accepted if count<DEPTH, or if a drain pops this cycle.
  - drain_req=1 with count>0 forces stall_o=1 for every store.
  - Otherwise stall_o=1 and the buffer is unchanged.
  - A push and a pop in the same cycle leave count unchanged.
- Read data path:
  - rd_valid_q, hit_q and fwd_q are registered from the read cycle.
  - core_rd_data = !rd_valid_q ? 0 : hit_q ? fwd_q : sram_rdata.
  - A read followed by a read to the same address returns consistent data because drains only write the oldest data.
- Loads are never stalled. A full buffer with a read miss and a store stalls the store only.
- Reset values:
  - count, head, tail, rd_valid_q, hit_q, fwd_q = 0.
  - core_rd_data=0, stall_o=0, idle_o=1, sram_cs=0, sram_we=0, sram_addr=0, sram_wdata=0.
- Reset mid-operation: buffered stores are discarded (not written); any in-flight read result is dropped.
- idle_o = (count==0).

Optional Feature:
- Macro DCCM_STORE_COALESCE_EN.
- Enabled:
  - A store whose waddr matches a buffered entry overwrites that entry's data in place, with no push.
  - It is accepted even when the buffer is full.
  - If the match is the head and the head drains this cycle, no coalesce: a normal push occurs.
  - If several entries match, the youngest is updated.
- Disabled: every accepted store pushes a new entry; duplicates drain in order.

Decomposition:
- Package dccm_store_buffer_pkg holds:
  - DEPTH default, pointer width via $clog2;
  - the entry typedef {waddr[SRAM_AW-1:0], data[31:0]};
  - a waddr-extract function.
- One sub-module, dccm_sb_match: combinational CAM over valid entries.
  - Returns a youngest-hit flag, its index, and data, from head, count and the query waddr.
  - Used once for the read and, if coalescing is enabled, once for the store.

Test Plan:
- Store 0x100 data 0xDEADBEEF, no reads -> next cycle sram_cs=1, we=1, sram_addr=0x40, wdata=0xDEADBEEF; idle_o=1 after.
- Same cycle: store 0x200 = 0x11111111 and load 0x200 -> core_rd_data=0x11111111 next cycle; no SRAM read issued.
- Back-to-back read misses with 5 stores -> 4 accepted, 5th stall_o=1 until the first non-miss cycle drains the head; final SRAM writes occur in order.
- Stores 0x300=A then 0x300=B buffered, then load 0x300 -> returns B. With DCCM_STORE_COALESCE_EN: one SRAM write of B. Without: two writes, A then B.
- Load from 0x400 (not buffered) with sram_rdata=0xCAFEF00D -> core_rd_data=0xCAFEF00D one cycle later; address 0x10400 aliases to the same word.
- 3 stores buffered, rst_n=0 for one cycle -> count=0, idle_o=1, no SRAM writes; drain_req with 2 entries -> stall_o=1 until idle_o=1.
